sb_bus_arbiter: RTL and testbench

Shares the single SB_SPI hard-IP system bus (SBSTBI/SBRWI/SBADRI/SBDATI/SBACKO/SBDATO) between N_REQ register-access requesters, e.g. a startup config sequencer and the RX poller. Each requester issues one 8-bit read or write at a time. Grants are round-robin. The block sequences the strobe/ack protocol and returns read data or a timeout error to the requester that was granted.

---
 rtl/sb_bus_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/sb_bus_arbiter.sv | 125 ++++++++++++
 tb/tb_sb_bus_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sb_bus_pkg.sv
// Shared types and SB register constants for the SB_SPI system-bus arbiter.
package sb_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    GAP
  } sb_arb_state_t;

  localparam logic [7:0] SB_ADDR_IRQ = 8'h00;
  localparam logic [7:0] SB_ADDR_RX  = 8'h05;

  localparam int unsigned IRQ_RRDY_BIT = 3;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester after the last grant, with wrap.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_k;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_k   = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      w_k = IW'((32'(i_last) + i) % N);
      if (!o_any && i_req[w_k]) begin
        o_any      = 1'b1;
        o_idx      = w_k;
        o_gnt[w_k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sb_bus_arbiter.sv
// Round-robin sharing of the SB_SPI system bus between N_REQ register-access
// requesters; sequences strobe/ack and returns data or a timeout error.
module sb_bus_arbiter
  import sb_bus_pkg::*;
#(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned TO_W        = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [N_REQ-1:0]          req_valid_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic [N_REQ-1:0]          req_rw_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata_i,
  output logic [N_REQ-1:0]          rsp_valid_o,
  output logic [DATA_W-1:0]         rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      busy_o,
  output logic                      sbstbi_o,
  output logic                      sbrwi_o,
  output logic [ADDR_W-1:0]         sbadri_o,
  output logic [DATA_W-1:0]         sbdati_o,
  input  logic                      sbacko_i,
  input  logic [DATA_W-1:0]         sbdato_i
);

  localparam int unsigned IW    = $clog2(N_REQ);
  localparam int unsigned CNT_W = (TO_W > 0) ? TO_W : 1;

  sb_arb_state_t     r_state;
  logic [IW-1:0]     r_last;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_stb;
  logic              r_rw;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;
  logic [N_REQ-1:0]  r_rsp_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [N_REQ-1:0]  w_gnt;
  logic [IW-1:0]     w_idx;
  logic              w_any;
  logic              w_to_hit;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .i_req  (req_valid_i),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // Watchdog expires on the last allowed strobe cycle; zero disables it.
  assign w_to_hit = (TIMEOUT_CYC != 0) && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  assign req_ready_o = (r_state == IDLE) ? w_gnt : '0;
  assign busy_o      = (r_state != IDLE);
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rdata;
  assign rsp_err_o   = r_err;
  assign sbstbi_o    = r_stb;
  assign sbrwi_o     = r_rw;
  assign sbadri_o    = r_adr;
  assign sbdati_o    = r_dat;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state     <= IDLE;
      r_last      <= IW'(N_REQ - 1);
      r_cnt       <= '0;
      r_stb       <= 1'b0;
      r_rw        <= 1'b1;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_rw    <= req_rw_i[w_idx];
            r_adr   <= req_addr_i[32'(w_idx) * ADDR_W +: ADDR_W];
            r_dat   <= req_wdata_i[32'(w_idx) * DATA_W +: DATA_W];
            r_stb   <= 1'b1;
            r_last  <= w_idx;
            r_cnt   <= '0;
            r_state <= STROBE;
          end
        end
        STROBE: begin
          // Ack takes priority over a coincident timeout.
          if (sbacko_i) begin
            r_stb               <= 1'b0;
            r_rdata             <= r_rw ? sbdato_i : '0;
            r_err               <= 1'b0;
            r_rsp_valid[r_last] <= 1'b1;
            r_state             <= GAP;
          end else if (w_to_hit) begin
            r_stb               <= 1'b0;
            r_rdata             <= '0;
            r_err               <= 1'b1;
            r_rsp_valid[r_last] <= 1'b1;
            r_state             <= GAP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        GAP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sb_bus_arbiter.sv
// Scoreboard bench for sb_bus_arbiter: two requesters, 4-cycle watchdog, bench-driven SB ack.
module tb_sb_bus_arbiter;

  localparam int unsigned N  = 2;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic            clk_i = 1'b0;
  logic            rstn_i = 1'b0;
  logic [N-1:0]    req_valid_i = '0;
  logic [N-1:0]    req_ready_o;
  logic [N-1:0]    req_rw_i = '0;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*DW-1:0] req_wdata_i = '0;
  logic [N-1:0]    rsp_valid_o;
  logic [DW-1:0]   rsp_rdata_o;
  logic            rsp_err_o;
  logic            busy_o;
  logic            sbstbi_o;
  logic            sbrwi_o;
  logic [AW-1:0]   sbadri_o;
  logic [DW-1:0]   sbdati_o;
  logic            sbacko_i = 1'b0;
  logic [DW-1:0]   sbdato_i = '0;

  typedef struct {
    int         idx;
    logic [7:0] rdata;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  sb_bus_arbiter #(
    .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rw_i(req_rw_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .busy_o(busy_o),
    .sbstbi_o(sbstbi_o), .sbrwi_o(sbrwi_o), .sbadri_o(sbadri_o), .sbdati_o(sbdati_o),
    .sbacko_i(sbacko_i), .sbdato_i(sbdato_i)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic wait_rsp(output bit timed_out);
    int n = 0;
    while (rsp_valid_o === '0 && n < 20) begin
      tick();
      n++;
    end
    timed_out = (rsp_valid_o === '0);
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    tick();
    tick();
    checks++;
    if ({sbstbi_o, sbrwi_o, sbadri_o, sbdati_o} !== {1'b0, 1'b1, 8'h00, 8'h00}) begin
      failures++;
      $display("FAIL reset_bus got stb=%b rw=%b adr=%h dat=%h required 0 1 00 00",
               sbstbi_o, sbrwi_o, sbadri_o, sbdati_o);
    end
    checks++;
    if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o} !== {2'b00, 8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_rsp got valid=%b rdata=%h err=%b busy=%b required 00 00 0 0",
               rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o);
    end
    rstn_i = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    exp_t e;
    logic [N-1:0] ev;
    bit to;
    int bad = 0;
    req_valid_i = 2'b01;
    req_rw_i[0] = 1'b1;
    req_addr_i[7:0] = 8'h05;
    #1;
    checks++;
    if (req_ready_o !== 2'b01) begin
      failures++;
      $display("FAIL read_ready got %b required 01", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    for (int c = 0; c < 4; c++) begin
      if (sbstbi_o !== 1'b1 || sbrwi_o !== 1'b1 || sbadri_o !== 8'h05 || busy_o !== 1'b1) bad++;
      if (c == 3) begin
        sbacko_i = 1'b1;
        sbdato_i = 8'hA7;
        sb_q.push_back('{0, 8'hA7, 1'b0});
      end
      tick();
    end
    sbacko_i = 1'b0;
    sbdato_i = '0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL read_strobe_hold got %0d bad cycles required 0", bad);
    end
    checks++;
    if (sbstbi_o !== 1'b0) begin
      failures++;
      $display("FAIL read_strobe_drop got stb=%b required 0", sbstbi_o);
    end
    wait_rsp(to);
    checks++;
    if (to || sb_q.size() == 0) begin
      failures++;
      $display("FAIL read_rsp missing valid=%b queued=%0d", rsp_valid_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      ev = N'(1) << e.idx;
      if (rsp_valid_o !== ev || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
        failures++;
        $display("FAIL read_rsp got valid=%b rdata=%h err=%b required valid=%b rdata=%h err=%b",
                 rsp_valid_o, rsp_rdata_o, rsp_err_o, ev, e.rdata, e.err);
      end
    end
    tick();
    checks++;
    if (rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL read_pulse_end got valid=%b busy=%b required 00 0", rsp_valid_o, busy_o);
    end
  endtask

  task automatic test_write();
    exp_t e;
    logic [N-1:0] ev;
    bit to;
    req_valid_i = 2'b10;
    req_rw_i[1] = 1'b0;
    req_addr_i[15:8] = 8'h00;
    req_wdata_i[15:8] = 8'hFF;
    #1;
    checks++;
    if (req_ready_o !== 2'b10) begin
      failures++;
      $display("FAIL write_ready got %b required 10", req_ready_o);
    end
    tick();
    req_valid_i = '0;
    checks++;
    if ({sbstbi_o, sbrwi_o, sbadri_o, sbdati_o} !== {1'b1, 1'b0, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL write_bus got stb=%b rw=%b adr=%h dat=%h required 1 0 00 ff",
               sbstbi_o, sbrwi_o, sbadri_o, sbdati_o);
    end
    sbacko_i = 1'b1;
    sbdato_i = 8'h5A;
    sb_q.push_back('{1, 8'h00, 1'b0});
    tick();
    sbacko_i = 1'b0;
    sbdato_i = '0;
    wait_rsp(to);
    checks++;
    if (to || sb_q.size() == 0) begin
      failures++;
      $display("FAIL write_rsp missing valid=%b queued=%0d", rsp_valid_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      ev = N'(1) << e.idx;
      if (rsp_valid_o !== ev || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
        failures++;
        $display("FAIL write_rsp got valid=%b rdata=%h err=%b required valid=%b rdata=%h err=%b",
                 rsp_valid_o, rsp_rdata_o, rsp_err_o, ev, e.rdata, e.err);
      end
    end
    tick();
  endtask

  task automatic test_contention();
    exp_t e;
    logic [N-1:0] ev;
    logic [7:0] exp_adr;
    bit to;
    int n;
    int low = 0;
    req_rw_i = 2'b11;
    req_addr_i = {8'h20, 8'h10};
    req_valid_i = 2'b11;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      while (sbstbi_o !== 1'b1 && n < 20) begin
        low++;
        tick();
        n++;
      end
      checks++;
      if (n >= 20) begin
        failures++;
        $display("FAIL contention_strobe_wait got no strobe for txn %0d", t);
        break;
      end
      if (t > 0) begin
        checks++;
        if (low < 2) begin
          failures++;
          $display("FAIL contention_gap got %0d low cycles required >=2", low);
        end
      end
      exp_adr = (t % 2 == 0) ? 8'h10 : 8'h20;
      if (sbadri_o !== exp_adr) begin
        failures++;
        $display("FAIL contention_order txn %0d got adr=%h required %h", t, sbadri_o, exp_adr);
      end
      if (t == 3) req_valid_i = '0;
      sbacko_i = 1'b1;
      sbdato_i = 8'(8'h30 + t);
      sb_q.push_back('{t % 2, 8'(8'h30 + t), 1'b0});
      tick();
      sbacko_i = 1'b0;
      low = 0;
      wait_rsp(to);
      checks++;
      if (to || sb_q.size() == 0) begin
        failures++;
        $display("FAIL contention_rsp missing valid=%b queued=%0d", rsp_valid_o, sb_q.size());
      end else begin
        e = sb_q.pop_front();
        ev = N'(1) << e.idx;
        if (rsp_valid_o !== ev || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
          failures++;
          $display("FAIL contention_rsp got valid=%b rdata=%h err=%b required valid=%b rdata=%h err=%b",
                   rsp_valid_o, rsp_rdata_o, rsp_err_o, ev, e.rdata, e.err);
        end
      end
    end
    req_valid_i = '0;
    tick();
  endtask

  task automatic test_timeout();
    exp_t e;
    logic [N-1:0] ev;
    bit to;
    int n = 0;
    req_rw_i[0] = 1'b1;
    req_addr_i[7:0] = 8'h05;
    req_valid_i = 2'b01;
    tick();
    req_valid_i = '0;
    sb_q.push_back('{0, 8'h00, 1'b1});
    while (sbstbi_o === 1'b1 && n < 20) begin
      n++;
      tick();
    end
    checks++;
    if (n != 4) begin
      failures++;
      $display("FAIL timeout_width got %0d strobe cycles required 4", n);
    end
    wait_rsp(to);
    checks++;
    if (to || sb_q.size() == 0) begin
      failures++;
      $display("FAIL timeout_rsp missing valid=%b queued=%0d", rsp_valid_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      ev = N'(1) << e.idx;
      if (rsp_valid_o !== ev || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
        failures++;
        $display("FAIL timeout_rsp got valid=%b rdata=%h err=%b required valid=%b rdata=%h err=%b",
                 rsp_valid_o, rsp_rdata_o, rsp_err_o, ev, e.rdata, e.err);
      end
    end
    sbacko_i = 1'b1;
    sbdato_i = 8'hEE;
    tick();
    tick();
    checks++;
    if (sbstbi_o !== 1'b0 || rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL late_ack got stb=%b valid=%b busy=%b required 0 00 0",
               sbstbi_o, rsp_valid_o, busy_o);
    end
    sbacko_i = 1'b0;
    sbdato_i = '0;
    req_rw_i[1] = 1'b0;
    req_addr_i[15:8] = 8'h07;
    req_wdata_i[15:8] = 8'h42;
    req_valid_i = 2'b10;
    tick();
    req_valid_i = '0;
    checks++;
    if ({sbstbi_o, sbrwi_o, sbadri_o, sbdati_o} !== {1'b1, 1'b0, 8'h07, 8'h42}) begin
      failures++;
      $display("FAIL after_timeout_bus got stb=%b rw=%b adr=%h dat=%h required 1 0 07 42",
               sbstbi_o, sbrwi_o, sbadri_o, sbdati_o);
    end
    sbacko_i = 1'b1;
    sbdato_i = 8'h11;
    sb_q.push_back('{1, 8'h00, 1'b0});
    tick();
    sbacko_i = 1'b0;
    wait_rsp(to);
    checks++;
    if (to || sb_q.size() == 0) begin
      failures++;
      $display("FAIL after_timeout_rsp missing valid=%b queued=%0d", rsp_valid_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      ev = N'(1) << e.idx;
      if (rsp_valid_o !== ev || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
        failures++;
        $display("FAIL after_timeout_rsp got valid=%b rdata=%h err=%b required valid=%b rdata=%h err=%b",
                 rsp_valid_o, rsp_rdata_o, rsp_err_o, ev, e.rdata, e.err);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid();
    req_rw_i[0] = 1'b1;
    req_addr_i[7:0] = 8'h05;
    req_valid_i = 2'b01;
    tick();
    req_valid_i = '0;
    tick();
    rstn_i = 1'b0;
    sbacko_i = 1'b1;
    sbdato_i = 8'h99;
    tick();
    checks++;
    if (sbstbi_o !== 1'b0 || sbrwi_o !== 1'b1 || rsp_valid_o !== 2'b00 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got stb=%b rw=%b valid=%b busy=%b required 0 1 00 0",
               sbstbi_o, sbrwi_o, rsp_valid_o, busy_o);
    end
    rstn_i = 1'b1;
    sbacko_i = 1'b0;
    sbdato_i = '0;
    tick();
    req_valid_i = 2'b11;
    #1;
    checks++;
    if (rsp_valid_o !== 2'b00 || req_ready_o !== 2'b01) begin
      failures++;
      $display("FAIL reset_mid_after got valid=%b ready=%b required 00 01", rsp_valid_o, req_ready_o);
    end
    req_valid_i = '0;
  endtask

  task automatic test_immediate_ack();
    exp_t e;
    logic [N-1:0] ev;
    bit to;
    req_rw_i = 2'b11;
    req_addr_i = {8'h20, 8'h10};
    req_valid_i = 2'b11;
    tick();
    req_valid_i = '0;
    checks++;
    if (sbstbi_o !== 1'b1 || sbadri_o !== 8'h10) begin
      failures++;
      $display("FAIL imm_first_grant got stb=%b adr=%h required 1 10", sbstbi_o, sbadri_o);
    end
    sbacko_i = 1'b1;
    sbdato_i = 8'h3C;
    sb_q.push_back('{0, 8'h3C, 1'b0});
    tick();
    sbacko_i = 1'b0;
    sbdato_i = '0;
    checks++;
    if (sbstbi_o !== 1'b0) begin
      failures++;
      $display("FAIL imm_width got stb=%b required 0", sbstbi_o);
    end
    wait_rsp(to);
    checks++;
    if (to || sb_q.size() == 0) begin
      failures++;
      $display("FAIL imm_rsp missing valid=%b queued=%0d", rsp_valid_o, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      ev = N'(1) << e.idx;
      if (rsp_valid_o !== ev || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
        failures++;
        $display("FAIL imm_rsp got valid=%b rdata=%h err=%b required valid=%b rdata=%h err=%b",
                 rsp_valid_o, rsp_rdata_o, rsp_err_o, ev, e.rdata, e.err);
      end
    end
    tick();
    tick();
  endtask

  initial begin
    tick();
    test_reset();
    test_single_read();
    test_write();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_immediate_ack();
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending responses required 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
